fns_enc_seq: RTL and testbench

- Sequential Fibonacci-numeral-system (FNS) encoder: converts a binary word into an N-bit FNS codeword, one codeword bit per clock, MSB first.
- Inverse of the combinational FNS decoders: decoding the produced codeword (sum of set-bit weights) returns the original value.
- Sits on the transmit side of the CAC datapath, between the binary data source and the bus driver.
- Valid/ready handshakes on both sides.

---
 rtl/fns_enc_seq.sv | 130 +++++++++++++
 tb/tb_fns_enc_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fns_enc_seq.sv
// Fibonacci-numeral-system encoder: binary word in, N-bit FNS codeword out, one bit per clock MSB first.
// Latency: N+1 cycles from accept to out_valid (1 cycle for an out-of-range word); one word per N+2 cycles.
// Backpressure: result held in HOLD until out_ready; in_ready is low outside IDLE (no skid).
module fns_enc_seq #(
    parameter int N  = 7,
    parameter int DW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] data_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  codeout,
    output logic          err,
    output logic          busy
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

    function automatic logic [N-1:0][DW:0] calc_w();
        int a, b, t;
        calc_w = '0;
        a = 1;
        b = 1;
        for (int i = 0; i < N; i++) begin
            calc_w[i] = (DW+1)'(a);
            t = a + b;
            a = b;
            b = t;
        end
    endfunction

    function automatic int calc_max();
        int a, b, t, s;
        a = 1;
        b = 1;
        s = 0;
        for (int i = 0; i < N; i++) begin
            s = s + a;
            t = a + b;
            a = b;
            b = t;
        end
        return s;
    endfunction

    localparam logic [N-1:0][DW:0] WT   = calc_w();
    localparam logic [DW:0]        MAXV = (DW+1)'(calc_max());

    state_t         state, state_nx;
    logic [DW:0]    rem, rem_nx;
    logic [KW-1:0]  kidx, kidx_nx;
    logic [N-1:0]   code_nx;
    logic           err_nx;
    logic [DW:0]    wk;
    logic [DW:0]    data_ext;
    logic           take;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == HOLD);
    assign busy      = (state == CONV);

    assign wk       = WT[kidx];
    assign data_ext = {1'b0, data_in};
    // One extra bit of headroom keeps the greedy subtract from wrapping.
    assign take     = (rem >= wk);

    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        kidx_nx  = kidx;
        code_nx  = codeout;
        err_nx   = err;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    rem_nx  = data_ext;
                    kidx_nx = KW'(N - 1);
                    if (data_ext > MAXV) begin
                        code_nx  = '1;
                        err_nx   = 1'b1;
                        state_nx = HOLD;
                    end else begin
                        code_nx  = '0;
                        err_nx   = 1'b0;
                        state_nx = CONV;
                    end
                end
            end
            CONV: begin
                code_nx[kidx] = take;
                if (take) begin
                    rem_nx = rem - wk;
                end
                if (kidx == '0) begin
                    state_nx = HOLD;
                end else begin
                    kidx_nx = kidx - 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rem     <= '0;
            kidx    <= '0;
            codeout <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nx;
            rem     <= rem_nx;
            kidx    <= kidx_nx;
            codeout <= code_nx;
            err     <= err_nx;
        end
    end

endmodule

// File: tb/tb_fns_enc_seq.sv
// Directed bench for fns_enc_seq: three instances (N=7, N=3, N=12) sharing stimulus, selected by sel.
// Results are checked against hand-computed codewords and a weighted-sum decode from literal weight tables.
module tb_fns_enc_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv;
    logic        outr;
    logic [15:0] din;
    int          sel;
    int          cyc = 0;

    logic        ir7, ov7, er7, bz7;
    logic [6:0]  co7;
    logic        ir3, ov3, er3, bz3;
    logic [2:0]  co3;
    logic        ir12, ov12, er12, bz12;
    logic [11:0] co12;

    logic        ir, ov, er, bz;
    logic [15:0] co;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fns_enc_seq #(.N(7), .DW(6)) u7 (
        .clk(clk), .rst(rst), .in_valid(iv && sel == 0), .in_ready(ir7), .data_in(din[5:0]),
        .out_valid(ov7), .out_ready(outr), .codeout(co7), .err(er7), .busy(bz7));
    fns_enc_seq #(.N(3), .DW(3)) u3 (
        .clk(clk), .rst(rst), .in_valid(iv && sel == 1), .in_ready(ir3), .data_in(din[2:0]),
        .out_valid(ov3), .out_ready(outr), .codeout(co3), .err(er3), .busy(bz3));
    fns_enc_seq #(.N(12), .DW(9)) u12 (
        .clk(clk), .rst(rst), .in_valid(iv && sel == 2), .in_ready(ir12), .data_in(din[8:0]),
        .out_valid(ov12), .out_ready(outr), .codeout(co12), .err(er12), .busy(bz12));

    always_comb begin
        ir = ir7; ov = ov7; er = er7; bz = bz7; co = 16'(co7);
        if (sel == 1) begin
            ir = ir3; ov = ov3; er = er3; bz = bz3; co = 16'(co3);
        end else if (sel == 2) begin
            ir = ir12; ov = ov12; er = er12; bz = bz12; co = 16'(co12);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int decode(input int s, input logic [15:0] c);
        int w7[7]   = '{1, 1, 2, 3, 5, 8, 13};
        int w3[3]   = '{1, 1, 2};
        int w12[12] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144};
        int sum = 0;
        for (int i = 0; i < 12; i++) begin
            if (c[i]) begin
                if (s == 0 && i < 7) sum += w7[i];
                else if (s == 1 && i < 3) sum += w3[i];
                else if (s == 2) sum += w12[i];
                else sum += 100000;
            end
        end
        return sum;
    endfunction

    // Entered just after a negedge; returns at the negedge where out_valid is first seen.
    // lat = clock edges between the accept edge and that sample; acc = accept edge number.
    task automatic send(input int v, output int lat, output int acc,
                        output logic [15:0] c, output logic e);
        int n;
        iv  = 1'b1;
        din = 16'(v);
        n = 0;
        while (!ir && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_seen", 32'(ir), 1);
        acc = cyc + 1;
        @(posedge clk);
        @(negedge clk);
        iv  = 1'b0;
        lat = 0;
        while (!ov && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("out_valid_seen", 32'(ov), 1);
        c = co;
        e = er;
    endtask

    initial begin
        int lat, acc, prev_acc, seen;
        logic [15:0] c;
        logic e;

        rst = 1'b1; iv = 1'b0; outr = 1'b1; din = '0; sel = 0;
        @(negedge clk);
        chk("rst_in_ready", 32'(ir), 0);
        chk("rst_out_valid", 32'(ov), 0);
        chk("rst_codeout", 32'(co), 0);
        chk("rst_err", 32'(er), 0);
        chk("rst_busy", 32'(bz), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(ir), 1);

        // 20 = 13 + 5 + 2
        send(20, lat, acc, c, e);
        chk("w20_lat", lat, 7);
        chk("w20_code", 32'(c), 32'b1010100);
        chk("w20_err", 32'(e), 0);
        @(negedge clk);
        chk("w20_idle_ov", 32'(ov), 0);
        chk("w20_idle_ir", 32'(ir), 1);

        // Back-to-back full legal range
        prev_acc = -1;
        for (int v = 0; v <= 33; v++) begin
            send(v, lat, acc, c, e);
            chk($sformatf("sweep7_dec_%0d", v), decode(0, c), v);
            chk($sformatf("sweep7_err_%0d", v), 32'(e), 0);
            chk($sformatf("sweep7_lat_%0d", v), lat, 7);
            if (v > 0) chk($sformatf("sweep7_gap_%0d", v), acc - prev_acc, 9);
            if (v == 0)  chk("sweep7_zero", 32'(c), 0);
            if (v == 33) chk("sweep7_max", 32'(c), 32'h7f);
            prev_acc = acc;
        end

        // Out-of-range words, then a legal one (7 = 5 + 2)
        send(34, lat, acc, c, e);
        chk("w34_lat", lat, 0);
        chk("w34_err", 32'(e), 1);
        chk("w34_code", 32'(c), 32'h7f);
        send(63, lat, acc, c, e);
        chk("w63_lat", lat, 0);
        chk("w63_err", 32'(e), 1);
        chk("w63_code", 32'(c), 32'h7f);
        send(7, lat, acc, c, e);
        chk("w7_err", 32'(e), 0);
        chk("w7_code", 32'(c), 32'b0010100);

        // Backpressure: 12 = 8 + 3 + 1, held while the next word waits
        @(negedge clk);
        outr = 1'b0;
        send(12, lat, acc, c, e);
        chk("bp12_code", 32'(c), 32'b0101010);
        iv = 1'b1;
        din = 16'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_ov_%0d", i), 32'(ov), 1);
            chk($sformatf("bp_hold_code_%0d", i), 32'(co), 32'b0101010);
            chk($sformatf("bp_hold_ir_%0d", i), 32'(ir), 0);
        end
        outr = 1'b1;
        send(3, lat, acc, c, e);
        chk("bp3_code", 32'(c), 32'b0001000);
        chk("bp3_lat", lat, 7);

        // Reset on the third conversion cycle of 30
        @(negedge clk);
        iv = 1'b1;
        din = 16'd30;
        seen = 0;
        while (!ir && seen < 50) begin
            @(negedge clk);
            seen++;
        end
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("r30_busy_before", 32'(bz), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("r30_ov", 32'(ov), 0);
        chk("r30_busy", 32'(bz), 0);
        chk("r30_ir_in_rst", 32'(ir), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("r30_ir_after", 32'(ir), 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ov) seen++;
        end
        chk("r30_no_output", seen, 0);

        // Other widths: full input range, legal and illegal
        sel = 1;
        @(negedge clk);
        for (int v = 0; v < 8; v++) begin
            send(v, lat, acc, c, e);
            if (v <= 4) begin
                chk($sformatf("n3_dec_%0d", v), decode(1, c), v);
                chk($sformatf("n3_err_%0d", v), 32'(e), 0);
            end else begin
                chk($sformatf("n3_err_%0d", v), 32'(e), 1);
                chk($sformatf("n3_code_%0d", v), 32'(c), 32'h7);
            end
        end
        sel = 2;
        @(negedge clk);
        for (int v = 0; v < 512; v++) begin
            send(v, lat, acc, c, e);
            if (v <= 376) begin
                chk($sformatf("n12_dec_%0d", v), decode(2, c), v);
                chk($sformatf("n12_err_%0d", v), 32'(e), 0);
            end else begin
                chk($sformatf("n12_err_%0d", v), 32'(e), 1);
                chk($sformatf("n12_code_%0d", v), 32'(c), 32'hfff);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
